writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Write-back stage of the Y86-64 pipeline. It owns the M→W pipeline register and the 15-entry register file. It exposes combinational read ports to decode and the W-stage forwarding values. A run/halt/error status FSM retires instructions and freezes architectural state on the first non-AOK status.

## Interface
Parameters:
- `RESET_SP`, default 64'd254: reset value of R4 (%rsp).

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: reset. Synchronous, active-high. One clock; reset is synchronous and active-high.
- `M_stat` in 4: memory-stage status, one-hot: AOK=4'h8, HLT=4'h4, ADR=4'h2, INS=4'h1.
- `M_icode` in 4: memory-stage icode.
- `M_dstE` in 4: memory-stage E destination register.
- `M_dstM` in 4: memory-stage M destination register.
- `M_valE` in 64: memory-stage E value.
- `m_valM` in 64: memory-stage loaded value.
- `W_stall` in 1: hold the W register.
- `W_bubble` in 1: load a bubble into the W register.
- `d_srcA` in 4: decode read-port A address.
- `d_srcB` in 4: decode read-port B address.
- `d_rvalA` out 64: register-file read data, port A.
- `d_rvalB` out 64: register-file read data, port B.
- `W_icode` out 4: W pipeline register, icode field.
- `W_dstE` out 4: W pipeline register, E destination (forwarding source for decode).
- `W_dstM` out 4: W pipeline register, M destination (forwarding source for decode).
- `W_valE` out 64: W pipeline register, E value (forwarding source for decode).
- `W_valM` out 64: W pipeline register, M value (forwarding source for decode).
- `W_stat` out 4: W pipeline register, status.
- `sys_stat` out 4: architectural status. AOK while running; otherwise the latched terminating code.
- `halted` out 1: FSM is not in RUN.
- `R0`…`R14` out 64 each: live register-file contents.
- `retire_cnt` out 64: retired instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
W register, evaluated at each posedge in priority order:
- `rst`: bubble.
- FSM not in RUN: hold.
- `W_stall`: hold.
- `W_bubble`: bubble.
- Otherwise: load the M_* inputs.
- Bubble contents: icode=4'h1, dstE=dstM=4'hF, valE=valM=0, stat=AOK.

Register file:
- Reset values, R0..R14: 12, 10, 101, 3, RESET_SP, 50, -143, 10000, 990000, -12345, 12345, 10112, 0, 1567, 8643.
- Writes occur only when all hold: FSM in RUN, W_stat=AOK, `rst`=0.
- valE is written to W_dstE when W_dstE≠4'hF.
- valM is written to W_dstM when W_dstM≠4'hF.
- If W_dstE==W_dstM (≠F), valM wins. Example: popq %rsp.
- Writes are not gated by icode. Upstream guarantees dst=F for non-writing instructions, including a failed cmovXX.

Read ports:
- Purely combinational: `d_rvalX = (d_srcX==4'hF) ? 0 : reg[d_srcX]`.
- No internal write→read bypass. Same-cycle W results reach decode through the W_* forwarding outputs.

Status FSM:
- States: RUN, HALT, ERR. Reset state is RUN.
- RUN → HALT when W_stat=HLT at a posedge; sys_stat←HLT.
- RUN → ERR when W_stat∈{ADR, INS} at a posedge; sys_stat←W_stat.
- W_stat with more than one bit set counts as INS.
- HALT and ERR are absorbing until `rst`.
- While halted: no register writes, W register frozen, counter frozen.

## Timing
- M→W latency: 1 cycle.
- A W-stage write is visible on d_rvalX and Rn one cycle after the W register loads it.
- `halted` and `sys_stat` update on the same edge at which the terminating instruction sits in W. The terminating instruction itself performs no write.
- Reset values:
  - W_* = bubble.
  - sys_stat = AOK (4'h8).
  - halted = 0.
  - retire_cnt = 0.
  - Registers = the values listed above.
- `rst` asserted mid-operation, including while halted, overrides everything on that edge.
- `W_stall` and `W_bubble` both asserted: stall wins.

## Configuration
- Macro: `WB_RETIRE_CNT_EN`.
- Defined:
  - `retire_cnt` exists.
  - It increments by 1 at each posedge where FSM=RUN, W_stat=AOK and W_icode≠4'h1.
  - It wraps modulo 2^64.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (IHALT..IPOPQ).
  - Status codes SAOK/SHLT/SADR/SINS.
  - RNONE=4'hF and RRSP=4'h4.
  - The W-register bubble constant.
- Natural sub-module: `y86_regfile`, with 2 combinational read ports, 2 write ports (M port has priority) and the reset image.
- The status FSM and W register stay in the top level.

## Test plan
- Reset: R3=3, R4=254, W_icode=1, sys_stat=4'h8, halted=0.
- Write and read-back: load M with irmovq (icode 3, dstE=2, valE=77, AOK). After 2 edges, R2=77 and d_srcA=2 gives d_rvalA=77.
- Dual-write conflict: load popq with dstE=4, dstM=4, valE=262, valM=500 → R4=500.
- Stall and bubble: hold W_stall for 3 cycles; W outputs stay constant. Assert W_stall and W_bubble together; W holds.
- Halt freeze: send HLT followed by irmovq to R1=99 → halted=1, sys_stat=4'h4, R1 remains 10, W frozen.
- ADR error, then reset: ADR in W → sys_stat=4'h2. Pulse `rst` → RUN, registers back to reset values, retire_cnt=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, register ids, the W-register
// layout with its bubble value, and the architectural register reset image.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h8;
  localparam logic [3:0] SHLT = 4'h4;
  localparam logic [3:0] SADR = 4'h2;
  localparam logic [3:0] SINS = 4'h1;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int unsigned NUM_REGS = 15;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    dst_e: RNONE,
    dst_m: RNONE,
    val_e: 64'd0,
    val_m: 64'd0
  };

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_ERR
  } wb_state_t;

  function automatic logic [63:0] reg_reset_value(input int unsigned idx,
                                                  input logic [63:0] sp);
    case (idx)
      0:       return 64'd12;
      1:       return 64'd10;
      2:       return 64'd101;
      3:       return 64'd3;
      4:       return sp;
      5:       return 64'd50;
      6:       return -64'sd143;
      7:       return 64'd10000;
      8:       return 64'd990000;
      9:       return -64'sd12345;
      10:      return 64'd12345;
      11:      return 64'd10112;
      12:      return 64'd0;
      13:      return 64'd1567;
      default: return 64'd8643;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry Y86-64 register file: two combinational read ports, an E and an M
// write port (M wins on a shared destination), and a fixed reset image.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_SP = 64'd254
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rval_a,
  output logic [63:0] rval_b,
  output logic [63:0] regs [NUM_REGS]
);

  // NOTE: every entry is reset because the architecture defines an initial
  // register image; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        // NOTE: non-blocking so all entries update from the same pre-edge view.
        regs[i] <= reg_reset_value(i, RESET_SP);
      end else if (we_m && dst_m == 4'(i)) begin
        regs[i] <= val_m;
      end else if (we_e && dst_e == 4'(i)) begin
        regs[i] <= val_e;
      end
    end
  end

  // NOTE: defaults first so no path leaves a read port unassigned (no latch).
  always_comb begin
    rval_a = '0;
    rval_b = '0;
    if (src_a != RNONE) rval_a = regs[src_a];
    if (src_b != RNONE) rval_b = regs[src_b];
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: M->W register, register file, run/halt/error status.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_SP = 64'd254
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  sys_stat,
  output logic        halted,
  output logic [63:0] R0,
  output logic [63:0] R1,
  output logic [63:0] R2,
  output logic [63:0] R3,
  output logic [63:0] R4,
  output logic [63:0] R5,
  output logic [63:0] R6,
  output logic [63:0] R7,
  output logic [63:0] R8,
  output logic [63:0] R9,
  output logic [63:0] R10,
  output logic [63:0] R11,
  output logic [63:0] R12,
  output logic [63:0] R13,
  output logic [63:0] R14
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt
`endif
);

  w_reg_t      w_q;
  wb_state_t   state_q, state_d;
  logic [3:0]  stat_q, stat_d;
  logic        wr_en;
  logic [63:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst)                   w_q <= W_BUBBLE;
    else if (state_q != ST_RUN) w_q <= w_q;
    else if (W_stall)          w_q <= w_q;
    else if (W_bubble)         w_q <= W_BUBBLE;
    else                       w_q <= '{stat: M_stat, icode: M_icode, dst_e: M_dstE,
                                        dst_m: M_dstM, val_e: M_valE, val_m: m_valM};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  // Anything that is not exactly AOK, HLT or ADR (including multi-hot) is INS.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (state_q == ST_RUN) begin
      case (w_q.stat)
        SAOK: ;
        SHLT: begin state_d = ST_HALT; stat_d = SHLT; end
        SADR: begin state_d = ST_ERR;  stat_d = SADR; end
        default: begin state_d = ST_ERR; stat_d = SINS; end
      endcase
    end
  end

  assign wr_en = (state_q == ST_RUN) && (w_q.stat == SAOK);

  y86_regfile #(.RESET_SP(RESET_SP)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we_e   (wr_en && (w_q.dst_e != RNONE)),
    .dst_e  (w_q.dst_e),
    .val_e  (w_q.val_e),
    .we_m   (wr_en && (w_q.dst_m != RNONE)),
    .dst_m  (w_q.dst_m),
    .val_m  (w_q.val_m),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .rval_a (d_rvalA),
    .rval_b (d_rvalB),
    .regs   (regs)
  );

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                             retire_cnt <= '0;
    else if (wr_en && w_q.icode != INOP) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

  assign W_icode  = w_q.icode;
  assign W_dstE   = w_q.dst_e;
  assign W_dstM   = w_q.dst_m;
  assign W_valE   = w_q.val_e;
  assign W_valM   = w_q.val_m;
  assign W_stat   = w_q.stat;
  assign sys_stat = stat_q;
  assign halted   = (state_q != ST_RUN);

  assign R0  = regs[0];
  assign R1  = regs[1];
  assign R2  = regs[2];
  assign R3  = regs[3];
  assign R4  = regs[4];
  assign R5  = regs[5];
  assign R6  = regs[6];
  assign R7  = regs[7];
  assign R8  = regs[8];
  assign R9  = regs[9];
  assign R10 = regs[10];
  assign R11 = regs[11];
  assign R12 = regs[12];
  assign R13 = regs[13];
  assign R14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios then random
// traffic, all compared against an instruction-level reference model.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic        W_stall, W_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [3:0]  W_icode, W_dstE, W_dstM, W_stat, sys_stat;
  logic [63:0] W_valE, W_valM;
  logic        halted;
  logic [63:0] r_obs [15];
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst(rst),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_stall(W_stall), .W_bubble(W_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE),
    .W_valM(W_valM), .W_stat(W_stat), .sys_stat(sys_stat), .halted(halted),
    .R0(r_obs[0]), .R1(r_obs[1]), .R2(r_obs[2]), .R3(r_obs[3]), .R4(r_obs[4]),
    .R5(r_obs[5]), .R6(r_obs[6]), .R7(r_obs[7]), .R8(r_obs[8]), .R9(r_obs[9]),
    .R10(r_obs[10]), .R11(r_obs[11]), .R12(r_obs[12]), .R13(r_obs[13]),
    .R14(r_obs[14])
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, the instruction sitting in W,
  // whether the machine is still running, its status code and retire count.
  int          reset_tab [15] = '{12, 10, 101, 3, 254, 50, -143, 10000, 990000,
                                  -12345, 12345, 10112, 0, 1567, 8643};
  logic [63:0] m_regs [15];
  logic [3:0]  mw_stat, mw_icode, mw_dste, mw_dstm;
  logic [63:0] mw_vale, mw_valm, m_cnt;
  bit          m_run;
  logic [3:0]  m_sys;

  function automatic void model_bubble();
    mw_stat = 4'h8; mw_icode = 4'h1; mw_dste = 4'hF; mw_dstm = 4'hF;
    mw_vale = 0;    mw_valm = 0;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        longint v = reset_tab[i];
        m_regs[i] = v;
      end
      model_bubble();
      m_run = 1; m_sys = 4'h8; m_cnt = 0;
    end else if (m_run) begin
      // Retire whatever is in W, then advance W from M.
      if (mw_stat == 4'h8) begin
        if (mw_dste != 4'hF) m_regs[int'(mw_dste)] = mw_vale;
        if (mw_dstm != 4'hF) m_regs[int'(mw_dstm)] = mw_valm;
        if (mw_icode != 4'h1) m_cnt = m_cnt + 1;
      end else begin
        m_run = 0;
        m_sys = (mw_stat == 4'h4) ? 4'h4 : (mw_stat == 4'h2) ? 4'h2 : 4'h1;
      end
      if (!W_stall) begin
        if (W_bubble) model_bubble();
        else begin
          mw_stat = M_stat; mw_icode = M_icode; mw_dste = M_dstE; mw_dstm = M_dstM;
          mw_vale = M_valE; mw_valm = m_valM;
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 15; i++) check($sformatf("R%0d", i), r_obs[i], m_regs[i]);
    check("W_stat",  W_stat,  mw_stat);
    check("W_icode", W_icode, mw_icode);
    check("W_dstE",  W_dstE,  mw_dste);
    check("W_dstM",  W_dstM,  mw_dstm);
    check("W_valE",  W_valE,  mw_vale);
    check("W_valM",  W_valM,  mw_valm);
    check("sys_stat", sys_stat, m_sys);
    check("halted",  halted,  !m_run);
    check("d_rvalA", d_rvalA, (d_srcA == 4'hF) ? 64'd0 : m_regs[int'(d_srcA)]);
    check("d_rvalB", d_rvalB, (d_srcB == 4'hF) ? 64'd0 : m_regs[int'(d_srcB)]);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_m(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    M_stat = st; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; d_srcA = 4'd3; d_srcB = 4'hF;
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);

    // Reset state
    do_reset();
    check("rst_R3", r_obs[3], 64'd3);
    check("rst_R4", r_obs[4], 64'd254);
    check("rst_W_icode", W_icode, 64'd1);
    check("rst_sys_stat", sys_stat, 64'h8);
    check("rst_halted", halted, 64'd0);

    // Write and read-back through port A
    d_srcA = 4'd2; d_srcB = 4'd6;
    set_m(4'h8, 4'h3, 4'd2, 4'hF, 64'd77, 64'd0);
    cycle();
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);
    cycle();
    check("irmovq_R2", r_obs[2], 64'd77);
    check("irmovq_rvalA", d_rvalA, 64'd77);

    // Same destination on both ports: M value wins
    set_m(4'h8, 4'hB, 4'd4, 4'd4, 64'd262, 64'd500);
    cycle();
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);
    cycle();
    check("popq_R4", r_obs[4], 64'd500);

    // Stall holds W; stall together with bubble still holds
    set_m(4'h8, 4'h3, 4'd5, 4'hF, 64'd1234, 64'd0);
    cycle();
    W_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(4'h8, 4'h6, 4'd7, 4'hF, 64'(i + 900), 64'd0);
      cycle();
      check("stall_W_valE", W_valE, 64'd1234);
    end
    W_bubble = 1'b1;
    cycle();
    check("stall_bubble_W_dstE", W_dstE, 64'd5);
    W_stall = 1'b0; W_bubble = 1'b0;
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);
    cycle();

    // Halt freezes state; the following irmovq never writes R1
    set_m(4'h4, 4'h0, 4'hF, 4'hF, 0, 0);
    cycle();
    set_m(4'h8, 4'h3, 4'd1, 4'hF, 64'd99, 64'd0);
    cycle();
    check("hlt_halted", halted, 64'd1);
    check("hlt_sys_stat", sys_stat, 64'h4);
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);
    cycle();
    cycle();
    check("hlt_R1", r_obs[1], 64'd10);
    check("hlt_W_valE", W_valE, 64'd99);

    // ADR error, then reset restores everything
    do_reset();
    set_m(4'h2, 4'h5, 4'hF, 4'd3, 0, 64'd42);
    cycle();
    set_m(4'h8, 4'h1, 4'hF, 4'hF, 0, 0);
    cycle();
    check("adr_sys_stat", sys_stat, 64'h2);
    check("adr_halted", halted, 64'd1);
    do_reset();
    check("adr_rst_sys_stat", sys_stat, 64'h8);
    check("adr_rst_halted", halted, 64'd0);
    check("adr_rst_R2", r_obs[2], 64'd101);
`ifdef WB_RETIRE_CNT_EN
    check("adr_rst_retire_cnt", retire_cnt, 64'd0);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] st;
      r = $urandom_range(0, 99);
      if (r < 86)      st = 4'h8;
      else if (r < 90) st = 4'h4;
      else if (r < 93) st = 4'h2;
      else if (r < 96) st = 4'h1;
      else             st = 4'($urandom_range(0, 15));
      set_m(st, 4'($urandom_range(0, 11)),
            ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      W_stall  = ($urandom_range(0, 9) == 0);
      W_bubble = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 24) == 0);
      d_srcA   = 4'($urandom_range(0, 15));
      d_srcB   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
